// File: rtl/cache_mem_pkg.sv
// Shared widths, op codes and FSM encoding for the block-granular memory responder.
package cache_mem_pkg;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned INDEX_W    = 6;
    localparam int unsigned NUM_BLOCKS = 64;
    localparam int unsigned CNT_W      = 4;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/block_ram_64x128.sv
// 64 x 128-bit array: synchronous write, registered read, no reset.
module block_ram_64x128
    import cache_mem_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [INDEX_W-1:0] addr,
    input  logic [BLOCK_W-1:0] wdata,
    output logic [BLOCK_W-1:0] rdata
);
    // Power-up contents are zero; reset deliberately never touches the array.
    logic [BLOCK_W-1:0] mem_q [NUM_BLOCKS] = '{default: '0};
    logic [BLOCK_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
        if (re) rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/cache_block_memory.sv
// Main-memory responder for the write-through cache: req/ready/done handshake with programmable latency.
module cache_block_memory
    import cache_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req,
    input  logic               read_cache,
    input  logic [ADDR_W-1:0]  addr_cache,
    input  logic [BLOCK_W-1:0] WriteData_cache,
    output logic [BLOCK_W-1:0] ReadData_mem,
    output logic               ready,
    output logic               done
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;
    logic               ram_we, ram_re;
    logic [BLOCK_W-1:0] ram_rdata;
    logic               unused_offset;

    assign unused_offset = ^addr_cache[3:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        ready_d    = ready_q;
        done_d     = done_q;
        rd_valid_d = rd_valid_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d    = read_cache;
                    idx_d   = addr_cache[ADDR_W-1:4];
                    wdata_d = WriteData_cache;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    ready_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    ram_we  = (op_q == OP_WRITE);
                    ram_re  = (op_q == OP_READ);
                    if (op_q == OP_READ) rd_valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                done_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_READ;
            idx_q      <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    block_ram_64x128 u_ram (
        .clk   (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // RAM read register has no reset; the valid flag gives ReadData_mem its reset value of zero.
    assign ReadData_mem = rd_valid_q ? ram_rdata : '0;
    assign ready        = ready_q;
    assign done         = done_q;
endmodule

// File: tb/tb_cache_block_memory.sv
// Directed bench for cache_block_memory at LATENCY=4 and LATENCY=1.
module tb_cache_block_memory;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0, rc = 1'b0;
    logic [9:0]   addr = '0;
    logic [127:0] wd = '0, rd;
    logic         ready, done;
    logic         req1 = 1'b0, rc1 = 1'b0;
    logic [9:0]   addr1 = '0;
    logic [127:0] wd1 = '0, rd1;
    logic         ready1, done1;

    int unsigned checks = 0;
    int unsigned failures = 0;

    localparam logic [127:0] D1  = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_F00D;
    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] DFF = {128{1'b1}};
    localparam logic [127:0] DX  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    always #5 clock = ~clock;

    cache_block_memory #(.LATENCY(4)) dut (
        .clock(clock), .reset(reset), .req(req), .read_cache(rc), .addr_cache(addr),
        .WriteData_cache(wd), .ReadData_mem(rd), .ready(ready), .done(done)
    );

    cache_block_memory #(.LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .req(req1), .read_cache(rc1), .addr_cache(addr1),
        .WriteData_cache(wd1), .ReadData_mem(rd1), .ready(ready1), .done(done1)
    );

    typedef struct {
        logic         op;
        logic [9:0]   addr;
        logic [127:0] wdata;
        logic [127:0] exp_rd;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One complete operation; inputs are scrambled after acceptance to prove they were latched.
    task automatic do_op(input bit sel, input logic op, input logic [9:0] a, input logic [127:0] d,
                         input int unsigned exp_lat, input logic [127:0] exp_rd, input string nm);
        int unsigned w = 0;
        int unsigned lat = 0;
        while (!(sel ? ready1 : ready) && w < 50) begin tick(); w++; end
        if (sel) begin req1 = 1'b1; rc1 = op; addr1 = a; wd1 = d; end
        else     begin req  = 1'b1; rc  = op; addr  = a; wd  = d; end
        tick();
        if (sel) begin req1 = 1'b0; rc1 = ~op; addr1 = ~a; wd1 = ~d; end
        else     begin req  = 1'b0; rc  = ~op; addr  = ~a; wd  = ~d; end
        chk({nm, " ready_drop"}, 128'(sel ? ready1 : ready), 128'(0));
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (sel ? done1 : done) begin lat = k; break; end
        end
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        chk({nm, " rdata"}, sel ? rd1 : rd, exp_rd);
        tick();
        chk({nm, " done_single"}, 128'(sel ? done1 : done), 128'(0));
        chk({nm, " ready_back"}, 128'(sel ? ready1 : ready), 128'(1));
    endtask

    initial begin
        vec_t vecs[6];
        int unsigned ndone;
        int unsigned t1, t2;
        vecs[0] = '{1'b0, 10'h000, '0,  '0};
        vecs[1] = '{1'b1, 10'h2A5, D1,  '0};
        vecs[2] = '{1'b0, 10'h2A0, '0,  D1};
        vecs[3] = '{1'b1, 10'h3F7, DA5, D1};
        vecs[4] = '{1'b0, 10'h3F0, '0,  DA5};
        vecs[5] = '{1'b0, 10'h3E0, '0,  '0};

        repeat (3) tick();
        reset = 1'b0;
        chk("rst ready", 128'(ready), 128'(1));
        chk("rst done", 128'(done), 128'(0));
        chk("rst rdata", rd, '0);
        chk("rst ready1", 128'(ready1), 128'(1));

        for (int i = 0; i < 6; i++)
            do_op(1'b0, vecs[i].op, vecs[i].addr, vecs[i].wdata, 4, vecs[i].exp_rd, $sformatf("vec%0d", i));
        do_op(1'b0, 1'b0, 10'h2A0, '0, 4, D1, "reread");
        chk("low word", 128'(rd[31:0]), 128'(32'hCAFE_F00D));

        // Busy rejection: a write request pulsed during WAIT must be dropped.
        req = 1'b1; rc = 1'b0; addr = 10'h2A0; wd = '0;
        tick();
        req = 1'b1; rc = 1'b1; wd = 128'h1;
        ndone = 0;
        chk("busy ready c0", 128'(ready), 128'(0));
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) req = 1'b0;
            if (k <= 4) chk($sformatf("busy ready c%0d", k), 128'(ready), 128'(0));
            if (done) ndone++;
        end
        chk("busy done count", 128'(ndone), 128'(1));
        chk("busy rdata", rd, D1);
        do_op(1'b0, 1'b0, 10'h2A0, '0, 4, D1, "busy block");

        // Reset two cycles into a write aborts it.
        req = 1'b1; rc = 1'b1; addr = 10'h100; wd = DFF;
        tick();
        req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("abort async ready", 128'(ready), 128'(1));
        chk("abort rdata reset", rd, '0);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort no done", 128'(ndone), 128'(0));
        do_op(1'b0, 1'b0, 10'h100, '0, 4, '0, "abort read");

        // LATENCY=1 instance.
        do_op(1'b1, 1'b1, 10'h040, DX, 1, '0, "l1 write");
        do_op(1'b1, 1'b0, 10'h04C, '0, 1, DX, "l1 read");
        req1 = 1'b1; rc1 = 1'b0; addr1 = 10'h040;
        tick();
        t1 = 0; t2 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done1) begin
                if (t1 == 0) t1 = k;
                else begin t2 = k; req1 = 1'b0; break; end
            end
        end
        req1 = 1'b0;
        chk("b2b first", 128'(t1), 128'(1));
        chk("b2b spacing", 128'(t2 - t1), 128'(3));
        chk("b2b rdata", rd1, DX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
